// File: rtl/alu_op_sequencer_if.sv
// Request handshake and register/ALU bus strobes between the decode unit and the op sequencer.
// The master side issues operations; the slave side (sequencer) drives the strobes.
interface alu_op_sequencer_if #(
   parameter int RSEL_W = 4
);
   logic              req_valid;
   logic              req_ready;
   logic [4:0]        req_opcode;
   logic [RSEL_W-1:0] req_ra;
   logic [RSEL_W-1:0] req_rb;
   logic [RSEL_W-1:0] req_rc;
   logic [RSEL_W-1:0] rsel;
   logic              r_out;
   logic              c_out;
   logic              y_in;
   logic [4:0]        alu_opcode;
   logic              z_in;
   logic              zlo_out;
   logic              zhi_out;
   logic              r_in;
   logic              lo_in;
   logic              hi_in;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_opcode, req_ra, req_rb, req_rc,
      input  req_ready, rsel, r_out, c_out, y_in, alu_opcode, z_in,
             zlo_out, zhi_out, r_in, lo_in, hi_in, done, err
   );

   modport slave (
      input  req_valid, req_opcode, req_ra, req_rb, req_rc,
      output req_ready, rsel, r_out, c_out, y_in, alu_opcode, z_in,
             zlo_out, zhi_out, r_in, lo_in, hi_in, done, err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle strobe sequencer for the HI/LO ALU: load Y, present B, capture Z, write back.
// Every output is decoded from the current state and the latched request fields only.
module alu_op_sequencer #(
   parameter int MULDIV_WAIT = 2,
   parameter int RSEL_W      = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   alu_op_sequencer_if.slave   bus
);
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [3:0] WAIT_INIT = 4'(MULDIV_WAIT);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_Y, S_EXEC, S_WB_LO, S_WB_HI, S_DONE, S_ERR
   } state_t;

   state_t            r_state, w_next;
   logic [4:0]        r_op;
   logic [RSEL_W-1:0] r_ra, r_rb, r_rc;
   logic [3:0]        r_cnt;

   logic              w_accept, w_req_bad, w_req_unary;
   logic              w_muldiv, w_imm, w_unary;
   logic [RSEL_W-1:0] w_rsel;
   logic              w_ready, w_r_out, w_c_out, w_y_in, w_z_in;
   logic              w_zlo_out, w_zhi_out, w_r_in, w_lo_in, w_hi_in, w_done, w_err;
   logic [4:0]        w_alu_op;

   assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
   assign w_req_bad   = (bus.req_opcode < OP_ADD) || (bus.req_opcode > OP_NOT);
   assign w_req_unary = (bus.req_opcode == OP_NEG) || (bus.req_opcode == OP_NOT);
   assign w_muldiv    = (r_op == OP_MUL) || (r_op == OP_DIV);
   assign w_imm       = (r_op >= OP_ADDI) && (r_op <= OP_ORI);
   assign w_unary     = (r_op == OP_NEG) || (r_op == OP_NOT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_ra    <= '0;
         r_rb    <= '0;
         r_rc    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op <= bus.req_opcode;
            r_ra <= bus.req_ra;
            r_rb <= bus.req_rb;
            r_rc <= bus.req_rc;
         end
         // mul/div always pass through LOAD_Y, so the settle count is armed there
         if (r_state == S_LOAD_Y && w_muldiv)
            r_cnt <= WAIT_INIT;
         else if (r_state == S_EXEC && r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_ready   = 1'b0;
      w_rsel    = '0;
      w_r_out   = 1'b0;
      w_c_out   = 1'b0;
      w_y_in    = 1'b0;
      w_alu_op  = 5'b00000;
      w_z_in    = 1'b0;
      w_zlo_out = 1'b0;
      w_zhi_out = 1'b0;
      w_r_in    = 1'b0;
      w_lo_in   = 1'b0;
      w_hi_in   = 1'b0;
      w_done    = 1'b0;
      w_err     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (bus.req_valid) begin
               if (w_req_bad)        w_next = S_ERR;
               else if (w_req_unary) w_next = S_EXEC;
               else                  w_next = S_LOAD_Y;
            end
         end
         S_LOAD_Y: begin
            w_rsel  = r_ra;
            w_r_out = 1'b1;
            w_y_in  = 1'b1;
            w_next  = S_EXEC;
         end
         S_EXEC: begin
            w_alu_op = r_op;
            if (w_imm) begin
               w_c_out = 1'b1;
            end else begin
               w_rsel  = w_unary ? r_ra : r_rb;
               w_r_out = 1'b1;
            end
            if (!(w_muldiv && r_cnt != 4'd0)) begin
               w_z_in = 1'b1;
               w_next = S_WB_LO;
            end
         end
         S_WB_LO: begin
            w_alu_op  = r_op;
            w_zlo_out = 1'b1;
            if (w_muldiv) begin
               w_lo_in = 1'b1;
               w_next  = S_WB_HI;
            end else begin
               w_rsel = r_rc;
               w_r_in = 1'b1;
               w_next = S_DONE;
            end
         end
         S_WB_HI: begin
            w_alu_op  = r_op;
            w_zhi_out = 1'b1;
            w_hi_in   = 1'b1;
            w_next    = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         S_ERR: begin
            w_done = 1'b1;
            w_err  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign bus.req_ready  = w_ready;
   assign bus.rsel       = w_rsel;
   assign bus.r_out      = w_r_out;
   assign bus.c_out      = w_c_out;
   assign bus.y_in       = w_y_in;
   assign bus.alu_opcode = w_alu_op;
   assign bus.z_in       = w_z_in;
   assign bus.zlo_out    = w_zlo_out;
   assign bus.zhi_out    = w_zhi_out;
   assign bus.r_in       = w_r_in;
   assign bus.lo_in      = w_lo_in;
   assign bus.hi_in      = w_hi_in;
   assign bus.done       = w_done;
   assign bus.err        = w_err;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: expected per-cycle strobe vectors are queued at issue
// time and a monitor compares one vector for every busy cycle the sequencer presents.
module tb_alu_op_sequencer;
   localparam int W  = 2;
   localparam int RW = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   alu_op_sequencer_if #(.RSEL_W(RW)) bus ();
   alu_op_sequencer #(.MULDIV_WAIT(W), .RSEL_W(RW)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   // {rsel, r_out, c_out, y_in, alu_opcode, z_in, zlo_out, zhi_out, r_in, lo_in, hi_in, done, err}
   logic [19:0] act;
   assign act = {bus.rsel, bus.r_out, bus.c_out, bus.y_in, bus.alu_opcode, bus.z_in,
                 bus.zlo_out, bus.zhi_out, bus.r_in, bus.lo_in, bus.hi_in, bus.done, bus.err};

   logic [19:0] sb[$];
   int n_vec  = 0;
   int n_miss = 0;

   function automatic logic [19:0] mk(input logic [3:0] rs, input logic ro, co, yi,
                                      input logic [4:0] op,
                                      input logic zi, zl, zh, ri, li, hi, dn, er);
      return {rs, ro, co, yi, op, zi, zl, zh, ri, li, hi, dn, er};
   endfunction

   task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: every busy cycle must match the next queued vector
   always @(negedge clk) begin
      if (reset_n && bus.req_ready !== 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_busy", act, 20'hFFFFF);
         end else begin
            chk("cycle_vec", act, sb.pop_front());
         end
      end
   end

   task automatic issue(input logic [4:0] op, input logic [3:0] ra, rb, rc);
      int guard = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("ready_timeout", {19'd0, bus.req_ready}, 20'd1);
      bus.req_valid  = 1'b1;
      bus.req_opcode = op;
      bus.req_ra     = ra;
      bus.req_rb     = rb;
      bus.req_rc     = rc;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      while ((sb.size() != 0 || bus.req_ready !== 1'b1) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) chk("drain_timeout", 20'(sb.size()), 20'd0);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_opcode = '0;
      bus.req_ra     = '0;
      bus.req_rb     = '0;
      bus.req_rc     = '0;
      #12;
      chk("reset_outputs", act, 20'd0);
      chk("reset_ready", {19'd0, bus.req_ready}, 20'd1);
      reset_n = 1'b1;

      // 1: add R3 <- R1 + R2
      sb.push_back(mk(1, 1, 0, 1, 5'd0,  0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(2, 1, 0, 0, 5'd3,  1, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(3, 0, 0, 0, 5'd3,  0, 1, 0, 1, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 0));
      issue(5'd3, 4'd1, 4'd2, 4'd3);
      drain();

      // 2: not R5 <- ~R5 (rb ignored), back-to-back with 1
      sb.push_back(mk(5, 1, 0, 0, 5'd18, 1, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(5, 0, 0, 0, 5'd18, 0, 1, 0, 1, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 0));
      issue(5'd18, 4'd5, 4'd9, 4'd5);
      drain();

      // 3: mul R7*R8 -> HI/LO, three EXEC cycles
      sb.push_back(mk(7, 1, 0, 1, 5'd0,  0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(8, 1, 0, 0, 5'd15, 0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(8, 1, 0, 0, 5'd15, 0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(8, 1, 0, 0, 5'd15, 1, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd15, 0, 1, 0, 0, 1, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd15, 0, 0, 1, 0, 0, 1, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 0));
      issue(5'd15, 4'd7, 4'd8, 4'd1);
      drain();

      // 4: addi R6 <- R4 + C (rb ignored)
      sb.push_back(mk(4, 1, 0, 1, 5'd0,  0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 1, 0, 5'd12, 1, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(6, 0, 0, 0, 5'd12, 0, 1, 0, 1, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 0));
      issue(5'd12, 4'd4, 4'd7, 4'd6);
      drain();

      // 5: invalid opcodes at both range edges and all-ones
      sb.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1));
      issue(5'd31, 4'd1, 4'd1, 4'd1);
      drain();
      sb.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1));
      issue(5'd2, 4'd1, 4'd1, 4'd1);
      drain();
      sb.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1));
      issue(5'd19, 4'd1, 4'd1, 4'd1);
      drain();

      // ori (last immediate) and neg (first unary) boundaries
      sb.push_back(mk(9, 1, 0, 1, 5'd0,  0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 1, 0, 5'd14, 1, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(10,0, 0, 0, 5'd14, 0, 1, 0, 1, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 0));
      issue(5'd14, 4'd9, 4'd3, 4'd10);
      sb.push_back(mk(11,1, 0, 0, 5'd17, 1, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(12,0, 0, 0, 5'd17, 0, 1, 0, 1, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 0));
      issue(5'd17, 4'd11, 4'd2, 4'd12);
      drain();

      // div R15/R14, also exercises the counter reload
      sb.push_back(mk(15,1, 0, 1, 5'd0,  0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(14,1, 0, 0, 5'd16, 0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(14,1, 0, 0, 5'd16, 0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(14,1, 0, 0, 5'd16, 1, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd16, 0, 1, 0, 0, 1, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd16, 0, 0, 1, 0, 0, 1, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 0, 0, 1, 0));
      issue(5'd16, 4'd15, 4'd14, 4'd0);
      drain();

      // 6: async reset in the middle of mul EXEC
      sb.push_back(mk(7, 1, 0, 1, 5'd0,  0, 0, 0, 0, 0, 0, 0, 0));
      issue(5'd15, 4'd7, 4'd8, 4'd1);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", act, 20'd0);
      chk("async_reset_ready", {19'd0, bus.req_ready}, 20'd1);
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("post_reset_ready", {19'd0, bus.req_ready}, 20'd1);

      // sub R2 <- R2 - R3 with req_valid held through the busy cycles
      sb.push_back(mk(2, 1, 0, 1, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(3, 1, 0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(mk(2, 0, 0, 0, 5'd4, 0, 1, 0, 1, 0, 0, 0, 0));
      sb.push_back(mk(0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0));
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_opcode = 5'd4;
      bus.req_ra     = 4'd2;
      bus.req_rb     = 4'd3;
      bus.req_rc     = 4'd2;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      drain();
      repeat (4) @(negedge clk);
      chk("idle_after_hold", {act[19:1], bus.req_ready}, 20'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
